float_max_reduce: RTL and testbench

//  Versat functional unit that sequences a single-precision max/min compare into a vector reduction.

---
 rtl/float_max_pkg.sv | 24 ++
 rtl/float_max_cmp.sv | 40 ++++
 rtl/float_max_reduce.sv | 103 ++++++++++
 tb/tb_float_max_reduce.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/float_max_pkg.sv
// Shared constants, FSM encoding and NaN helper for the float max/min reduction unit.
// binary32 only: field widths and special encodings are fixed here.
package float_max_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int FP_W  = 1 + EXP_W + MAN_W;

    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F800000;
    localparam logic [FP_W-1:0] FP_NEG_INF = 32'hFF800000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (&x[MAN_W +: EXP_W]) && (|x[MAN_W-1:0]);
    endfunction

endpackage

// File: rtl/float_max_cmp.sv
// Combinational binary32 max/min select; result is always a or b, or canonical qNaN.
// Latency 0; no flow control.
module float_max_cmp
    import float_max_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            max_n_min,
    output logic [FP_W-1:0] res
);

    logic            a_nan;
    logic            b_nan;
    logic            a_gt_b;
    logic [FP_W-1:0] ka;
    logic [FP_W-1:0] kb;

    // Map sign-magnitude onto an unsigned total order: -0 sorts just below +0.
    assign ka     = a[FP_W-1] ? ~a : {1'b1, a[FP_W-2:0]};
    assign kb     = b[FP_W-1] ? ~b : {1'b1, b[FP_W-2:0]};
    assign a_gt_b = ka > kb;
    assign a_nan  = is_nan(a);
    assign b_nan  = is_nan(b);

    always_comb begin
        res = a;
        if (a_nan && b_nan) begin
            res = FP_QNAN;
        end else if (a_nan) begin
            res = b;
        end else if (b_nan) begin
            res = a;
        end else if (max_n_min) begin
            res = a_gt_b ? a : b;
        end else begin
            res = a_gt_b ? b : a;
        end
    end

endmodule

// File: rtl/float_max_reduce.sv
// Versat unit reducing LEN binary32 samples of in0 to their max/min, starting DELAY cycles after run.
// Result and done appear 1 cycle after the last sample; running=0 stalls counters and out0.
module float_max_reduce
    import float_max_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic               run,
    input  logic [LEN_W-1:0]   len,
    input  logic [DELAY_W-1:0] delay,
    input  logic               max_n_min,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    output logic               done
);

    state_t             state, state_n;
    logic [DELAY_W-1:0] dcnt, dcnt_n;
    logic [LEN_W-1:0]   scnt, scnt_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               mnm_q, mnm_n;
    logic [DATA_W-1:0]  out_n;
    logic [DATA_W-1:0]  cmp_res;

    float_max_cmp u_cmp (
        .a         (out0),
        .b         (in0),
        .max_n_min (mnm_q),
        .res       (cmp_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            dcnt  <= '0;
            scnt  <= '0;
            len_q <= '0;
            mnm_q <= 1'b0;
            out0  <= '0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            scnt  <= scnt_n;
            len_q <= len_n;
            mnm_q <= mnm_n;
            out0  <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        scnt_n  = scnt;
        len_n   = len_q;
        mnm_n   = mnm_q;
        out_n   = out0;
        // run has priority in every state, including over a last sample in ACC.
        if (run) begin
            len_n  = len;
            mnm_n  = max_n_min;
            dcnt_n = delay;
            scnt_n = '0;
            if (len == '0) begin
                state_n = ST_DONE;
                out_n   = max_n_min ? FP_NEG_INF : FP_POS_INF;
            end else if (delay != '0) begin
                state_n = ST_WAIT;
            end else begin
                state_n = ST_ACC;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    if (running) begin
                        dcnt_n = dcnt - DELAY_W'(1);
                        if (dcnt == DELAY_W'(1)) begin
                            state_n = ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (running) begin
                        out_n = (scnt == '0) ? in0 : cmp_res;
                        if (scnt == len_q - LEN_W'(1)) begin
                            state_n = ST_DONE;
                        end else begin
                            scnt_n = scnt + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_float_max_reduce.sv
// Directed bench for float_max_reduce: real-valued reference model plus per-cycle done/out0 checks.
module tb_float_max_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        running;
    logic        run;
    logic [15:0] len;
    logic [7:0]  delay;
    logic        max_n_min;
    logic [31:0] in0;
    logic [31:0] out0;
    logic        done;

    always #5 clk = ~clk;

    float_max_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .running   (running),
        .run       (run),
        .len       (len),
        .delay     (delay),
        .max_n_min (max_n_min),
        .in0       (in0),
        .out0      (out0),
        .done      (done)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          run_cyc = 0;
    int          rise_cyc = 0;
    logic        chk_en = 1'b0;
    logic        exp_after = 1'b0;
    logic [31:0] exp_out = '0;
    logic        done_prev = 1'b0;
    logic [31:0] smp [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: decode to real, order numerically, break the +-0 tie by sign.
    function automatic real f2r(input logic [31:0] x);
        real v;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)    v = 1.0e300;
        else if (e == 0) v = real'(x[22:0]) * (2.0 ** -149);
        else             v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -v : v;
    endfunction

    function automatic logic isnan_m(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic logic [31:0] mcmp(input logic [31:0] a, input logic [31:0] b, input logic mx);
        real ra, rb;
        if (isnan_m(a) && isnan_m(b)) return 32'h7FC00000;
        if (isnan_m(a)) return b;
        if (isnan_m(b)) return a;
        ra = f2r(a);
        rb = f2r(b);
        if (ra == rb) return mx ? (a[31] ? b : a) : (a[31] ? a : b);
        if (mx) return (ra > rb) ? a : b;
        return (ra < rb) ? a : b;
    endfunction

    function automatic logic [31:0] model_reduce(input int n, input logic mx);
        logic [31:0] acc;
        if (n == 0) return mx ? 32'hFF800000 : 32'h7F800000;
        acc = smp[0];
        for (int i = 1; i < n; i++) acc = mcmp(acc, smp[i], mx);
        return acc;
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input logic [31:0] e);
        smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d; smp[4] = e;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle check: done every cycle, out0 whenever the result must be valid.
    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("done", {31'b0, done}, {31'b0, exp_after});
            if (exp_after) check("out0", out0, exp_out);
            if (done && !done_prev) rise_cyc = cyc;
        end
        done_prev = done;
    end

    task automatic idle(input int n, input logic [31:0] junk);
        repeat (n) begin
            @(negedge clk);
            run = 1'b0; running = 1'b1; in0 = junk;
        end
    endtask

    task automatic partial(input int l, input int n, input logic mx);
        @(negedge clk);
        run = 1'b1; len = 16'(l); delay = 8'd0; max_n_min = mx; running = 1'b1; in0 = '0;
        exp_after = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            run = 1'b0; running = 1'b1; in0 = smp[i];
        end
    endtask

    task automatic do_case(input int l, input int d, input logic mx, input logic [15:0] stall,
                           input logic [31:0] lit);
        logic [31:0] m;
        logic [31:0] junk;
        int          rc, si, step;
        m = model_reduce(l, mx);
        check("model", m, lit);
        junk = mx ? 32'h42C80000 : 32'hC2C80000;
        @(negedge clk);
        run = 1'b1; len = 16'(l); delay = 8'(d); max_n_min = mx; running = 1'b1; in0 = junk;
        exp_out = m; exp_after = (l == 0); run_cyc = cyc;
        rc = 0; si = 0; step = 0;
        while (si < l && step < 64) begin
            @(negedge clk);
            run = 1'b0;
            running = !(step < 16 && stall[step]);
            step++;
            in0 = junk;
            if (running) begin
                if (rc < d) rc++;
                else begin
                    in0 = smp[si];
                    si++;
                end
            end
            exp_after = (si == l);
        end
        idle(2, junk);
        check("final", out0, lit);
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; running = 1'b0; len = '0; delay = '0;
        max_n_min = 1'b1; in0 = '0;
        #12;
        check("rst_out0", out0, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        idle(3, 32'h0);

        check("pin_inf", mcmp(32'h7F800000, 32'h7F7FFFFF, 1'b1), 32'h7F800000);
        check("pin_zero", mcmp(32'h00000000, 32'h80000000, 1'b0), 32'h80000000);

        load(32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000, 32'h0);
        do_case(4, 0, 1'b1, 16'h0000, 32'h40600000);
        check("lat_case1", 32'(rise_cyc - run_cyc), 32'd5);

        load(32'h00000000, 32'h80000000, 32'h40E00000, 32'h0, 32'h0);
        do_case(3, 2, 1'b0, 16'h0000, 32'h80000000);

        load(32'h7FC00001, 32'h40000000, 32'hFFC00000, 32'h0, 32'h0);
        do_case(3, 0, 1'b1, 16'h0000, 32'h40000000);
        load(32'h7FC00001, 32'hFF800001, 32'h0, 32'h0, 32'h0);
        do_case(2, 0, 1'b1, 16'h0000, 32'h7FC00000);
        load(32'h7FC00001, 32'h0, 32'h0, 32'h0, 32'h0);
        do_case(1, 0, 1'b0, 16'h0000, 32'h7FC00001);

        load(32'h3F800000, 32'h40A00000, 32'hC0400000, 32'h40200000, 32'h40800000);
        do_case(5, 0, 1'b1, 16'h000C, 32'h40A00000);
        check("lat_stall", 32'(rise_cyc - run_cyc), 32'd8);

        do_case(0, 0, 1'b1, 16'h0000, 32'hFF800000);
        do_case(0, 3, 1'b0, 16'h0000, 32'h7F800000);

        load(32'h00000001, 32'h80000001, 32'hFF800000, 32'h3F800000, 32'h0);
        do_case(4, 1, 1'b0, 16'h0001, 32'hFF800000);
        load(32'h00000001, 32'h00000002, 32'h80000005, 32'h0, 32'h0);
        do_case(3, 3, 1'b1, 16'h0000, 32'h00000002);
        load(32'h80000000, 32'h00000000, 32'h0, 32'h0, 32'h0);
        do_case(2, 0, 1'b1, 16'h0000, 32'h00000000);

        // Asynchronous reset in the middle of an accumulation.
        load(32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 32'h0);
        partial(6, 3, 1'b1);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_out0", out0, 32'h0);
        check("arst_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        exp_after = 1'b0;
        chk_en = 1'b1;
        idle(3, 32'h42C80000);

        // Restart mid-ACC with a new length.
        load(32'h40A00000, 32'h40C00000, 32'h0, 32'h0, 32'h0);
        partial(6, 2, 1'b1);
        load(32'hC0000000, 32'hBF800000, 32'hC0400000, 32'h0, 32'h0);
        do_case(3, 0, 1'b1, 16'h0000, 32'hBF800000);

        // run arriving with what would have been the last sample: no done from the old run.
        load(32'h41200000, 32'h0, 32'h0, 32'h0, 32'h0);
        partial(2, 1, 1'b0);
        load(32'h40400000, 32'hC1200000, 32'h0, 32'h0, 32'h0);
        do_case(2, 0, 1'b0, 16'h0000, 32'hC1200000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
